// File: rtl/muxn_pkg.sv
// -----------------------------------------------------------------------------
// muxn_pkg
//   Shared definitions for the muxn_pipe N-way registered selector.
//   Provides the select-mode enum, the index-width helper used to size the
//   select/source ports, and the reset value of the round-robin pointer.
//   The round-robin pieces are only used when MUXN_RR_EN is defined.
// -----------------------------------------------------------------------------
package muxn_pkg;

  // How the channel index is chosen on a given cycle.
  typedef enum logic {
    MODE_EXPLICIT = 1'b0,
    MODE_RR       = 1'b1
  } sel_mode_e;

  // Index width for n channels; never below 1 so a 2-way mux still has a
  // real select bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // The round-robin pointer parks on the last channel after reset so the
  // first scan starts at channel 0.
  function automatic int ptr_reset(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/muxn_rr_arb.sv
// -----------------------------------------------------------------------------
// muxn_rr_arb
//   Round-robin arbiter for muxn_pipe. Scans the request vector starting
//   one past the pointer (ptr+1, ptr+2, ... wrapping mod N) and reports the
//   first requesting channel. Purely combinational; the pointer register
//   lives in the top level so it only moves on a real grant.
//   The module body is compiled only when MUXN_RR_EN is defined, since it
//   has no user in the explicit-select build.
// Parameters
//   N      number of channels (N >= 2)
//   SELW   index width
// Ports
//   req      in   N     per-channel request (the channel's in_valid)
//   ptr      in   SELW  index of the most recently granted channel
//   gnt_idx  out  SELW  chosen channel (0 when nothing requests)
//   gnt_any  out  1     some channel requested
// -----------------------------------------------------------------------------
`ifdef MUXN_RR_EN
module muxn_rr_arb
  import muxn_pkg::*;
#(
  parameter int N    = 2,
  parameter int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  // Walk the channels once in rotating order from ptr+1; the first request
  // seen wins and later ones are ignored.
  always_comb begin
    logic [SELW-1:0] idx;
    idx     = ptr;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (idx == SELW'(N - 1)) ? '0 : idx + 1'b1;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule
`endif

// File: rtl/muxn_pipe.sv
// -----------------------------------------------------------------------------
// muxn_pipe
//   N-way, WIDTH-bit selector with one registered output stage and
//   valid/ready handshakes on every input channel and on the output.
//   Used for writeback/forward selection where each source can stall on
//   its own. The chosen channel is either the explicit select or, when the
//   MUXN_RR_EN macro is defined and rr_mode is high, the next valid channel
//   in round-robin order. Without MUXN_RR_EN, rr_mode is ignored and no
//   pointer or arbiter is built.
// Parameters
//   WIDTH  data bits per channel
//   N      number of channels (N >= 2); SELW = clog2(N) is derived
// Ports
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high reset
//   in_data    in   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   N        channel i offers a word
//   in_ready   out  N        channel i word taken when in_valid[i] && in_ready[i]
//   sel        in   SELW     explicit channel select
//   rr_mode    in   1        round-robin select (MUXN_RR_EN builds only)
//   out_data   out  WIDTH    registered selected word
//   out_src    out  SELW     channel that supplied out_data
//   out_valid  out  1        out_data/out_src hold a word
//   out_ready  in   1        consumer takes the word when out_valid && out_ready
// -----------------------------------------------------------------------------
module muxn_pipe
  import muxn_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 2,
  localparam int SELW  = clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  input  logic               rr_mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             load_ok;
  logic [SELW-1:0]  choice;
  logic             choice_ok;
  logic             grant;
  logic [WIDTH-1:0] chosen_word;

`ifdef MUXN_RR_EN
  localparam logic [SELW-1:0] PTR_RST = SELW'(ptr_reset(N));

  sel_mode_e       mode;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_idx;
  logic            rr_any;

  assign mode = rr_mode ? MODE_RR : MODE_EXPLICIT;

  muxn_rr_arb #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // The pointer remembers the last granted channel in either mode, so a
  // switch into round-robin continues from wherever traffic last came from.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= PTR_RST;
    end else if (grant) begin
      rr_ptr <= choice;
    end
  end
`else
  logic unused_rr_mode;
  assign unused_rr_mode = rr_mode;
`endif

  // The register can take a new word when it is empty or its word is being
  // popped this same cycle, which keeps throughput at one word per cycle.
  assign load_ok = !out_valid || out_ready;

  // Pick the candidate channel. An explicit select past the last channel
  // (possible when N is not a power of two) names nobody.
  always_comb begin
    choice    = sel;
    choice_ok = ({1'b0, sel} < (SELW + 1)'(N));
`ifdef MUXN_RR_EN
    if (mode == MODE_RR) begin
      choice    = rr_idx;
      choice_ok = rr_any;
    end
`endif
  end

  // At most one ready bit, and none while resetting. In explicit mode the
  // ready bit is offered whether or not that channel is valid.
  always_comb begin
    in_ready = '0;
    if (!reset && load_ok && choice_ok) begin
      in_ready[choice] = 1'b1;
    end
  end

  assign grant = |(in_ready & in_valid);

  // Only the chosen lane is read, so nothing from the other channels can
  // leak into the output register.
  always_comb begin
    chosen_word = '0;
    if (choice_ok) begin
      chosen_word = in_data[choice*WIDTH +: WIDTH];
    end
  end

  // Output stage: load on grant, drop valid when the word leaves with no
  // replacement, and otherwise hold (including the stalled case).
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= chosen_word;
      out_src   <= choice;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muxn_pipe.sv
// -----------------------------------------------------------------------------
// tb_muxn_pipe
//   Bench for muxn_pipe with three instances: N=2/WIDTH=32, N=3/WIDTH=8 and
//   N=4/WIDTH=16. Round-robin expectations follow MUXN_RR_EN.
// -----------------------------------------------------------------------------
module tb_muxn_pipe;
  import muxn_pkg::*;

  localparam int NCFG = 3;
  localparam int MAXN = 4;
  localparam int MAXW = 32;

`ifdef MUXN_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic [MAXW-1:0] drv_data   [NCFG][MAXN];
  logic [MAXN-1:0] drv_valid  [NCFG];
  logic [1:0]      drv_sel    [NCFG];
  logic            drv_rr     [NCFG];
  logic            drv_oready [NCFG];

  logic [MAXW-1:0] obs_data  [NCFG];
  logic [1:0]      obs_src   [NCFG];
  logic            obs_valid [NCFG];
  logic [MAXN-1:0] obs_ready [NCFG];

  int checks = 0;
  int errors = 0;

  logic log_en = 1'b0;
  int   rr_log[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", tag, actual, expected);
    end
  endtask

  // Channel the design should offer ready to: n means nobody.
  function automatic int pick(input int n, input int ptr, input logic [MAXN-1:0] valid,
                              input int sel, input logic rr);
    int c;
    c = (sel < n) ? sel : n;
    if (RR_BUILD && rr) begin
      c = n;
      for (int k = 1; k <= n; k++) begin
        int idx;
        idx = (ptr + k) % n;
        if (c == n && valid[idx]) c = idx;
      end
    end
    return c;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int NN = (g == 0) ? 2 : ((g == 1) ? 3 : 4);
    localparam int WW = (g == 0) ? 32 : ((g == 1) ? 8 : 16);
    localparam int SW = clog2(NN);

    logic [NN*WW-1:0] in_data;
    logic [NN-1:0]    in_valid;
    logic [NN-1:0]    in_ready;
    logic [SW-1:0]    sel;
    logic             rr_mode;
    logic [WW-1:0]    out_data;
    logic [SW-1:0]    out_src;
    logic             out_valid;
    logic             out_ready;

    for (genvar i = 0; i < NN; i++) begin : lane
      assign in_data[i*WW +: WW] = drv_data[g][i][WW-1:0];
    end
    assign in_valid     = drv_valid[g][NN-1:0];
    assign sel          = drv_sel[g][SW-1:0];
    assign rr_mode      = drv_rr[g];
    assign out_ready    = drv_oready[g];
    assign obs_data[g]  = MAXW'(out_data);
    assign obs_src[g]   = 2'(out_src);
    assign obs_valid[g] = out_valid;
    assign obs_ready[g] = MAXN'(in_ready);

    muxn_pipe #(
      .WIDTH (WW),
      .N     (NN)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .rr_mode   (rr_mode),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
    );

    logic          m_valid = 1'b0;
    int            m_ptr   = NN - 1;
    logic [WW-1:0] m_data  = '0;
    int            m_src   = 0;
    logic [WW-1:0] exp_data[$];
    int            exp_src[$];

    // Mid-cycle look at the handshake and the output register.
    always @(negedge clk) begin
      int c;
      logic [MAXN-1:0] exp_ready;
      c = pick(NN, m_ptr, MAXN'(in_valid), int'(sel), rr_mode);
      exp_ready = '0;
      if (!reset && (!m_valid || out_ready) && c < NN) exp_ready = MAXN'(1) << c;
      checkOutput($sformatf("cfg%0d in_ready", g), 64'(in_ready), 64'(exp_ready));
      checkOutput($sformatf("cfg%0d out_valid", g), 64'(out_valid), 64'(m_valid));
      if (m_valid && exp_data.size() > 0) begin
        checkOutput($sformatf("cfg%0d out_data", g), 64'(out_data), 64'(exp_data[0]));
        checkOutput($sformatf("cfg%0d out_src", g), 64'(out_src), 64'(exp_src[0]));
        if (out_ready) begin
          void'(exp_data.pop_front());
          void'(exp_src.pop_front());
        end
      end else if (!m_valid) begin
        checkOutput($sformatf("cfg%0d held data", g), 64'(out_data), 64'(m_data));
        checkOutput($sformatf("cfg%0d held src", g), 64'(out_src), 64'(m_src));
      end
      if (g == 2 && log_en && out_valid && out_ready) rr_log.push_back(int'(out_src));
    end

    // Expected register contents after each edge.
    always @(posedge clk) begin
      int c;
      if (reset) begin
        m_valid = 1'b0;
        m_ptr   = NN - 1;
        m_data  = '0;
        m_src   = 0;
        exp_data.delete();
        exp_src.delete();
      end else begin
        c = pick(NN, m_ptr, MAXN'(in_valid), int'(sel), rr_mode);
        if ((!m_valid || out_ready) && c < NN &&
            ((MAXN'(in_valid) >> c) & MAXN'(1)) != '0) begin
          m_data  = drv_data[g][c][WW-1:0];
          m_src   = c;
          m_valid = 1'b1;
          m_ptr   = c;
          exp_data.push_back(m_data);
          exp_src.push_back(c);
        end else if (out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int g, input logic [MAXN-1:0] valid, input int sel,
                               input logic rr, input logic oready);
    drv_valid[g]  = valid;
    drv_sel[g]    = 2'(sel);
    drv_rr[g]     = rr;
    drv_oready[g] = oready;
  endtask

  int exp_log[$];

  initial begin
    reset = 1'b1;
    for (int g = 0; g < NCFG; g++) begin
      applyStimulus(g, '0, 0, 1'b0, 1'b1);
      for (int i = 0; i < MAXN; i++) drv_data[g][i] = 32'(g * 16 + i + 1);
    end
    tick(2);
    reset = 1'b0;

    // Explicit select of channel 1 on the 2-way, 32-bit instance.
    drv_data[0][0] = 32'h12345678;
    drv_data[0][1] = 32'hDEADBEEF;
    applyStimulus(0, 4'b0011, 1, 1'b0, 1'b1);
    tick(1);
    checkOutput("t1 data", 64'(obs_data[0]), 64'h00000000DEADBEEF);
    checkOutput("t1 src", 64'(obs_src[0]), 64'd1);
    checkOutput("t1 valid", 64'(obs_valid[0]), 64'd1);

    // Consumer stalls for three cycles, then pops while a new word waits.
    drv_data[0][0] = 32'hA5A5A5A5;
    applyStimulus(0, 4'b0001, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checkOutput("t2 stall data", 64'(obs_data[0]), 64'h00000000DEADBEEF);
      checkOutput("t2 stall ready", 64'(obs_ready[0]), 64'd0);
      checkOutput("t2 stall valid", 64'(obs_valid[0]), 64'd1);
    end
    drv_oready[0] = 1'b1;
    tick(1);
    checkOutput("t2 reload data", 64'(obs_data[0]), 64'h00000000A5A5A5A5);
    checkOutput("t2 reload valid", 64'(obs_valid[0]), 64'd1);
    checkOutput("t2 reload src", 64'(obs_src[0]), 64'd0);
    drv_valid[0] = '0;
    tick(1);
    checkOutput("t2 drain valid", 64'(obs_valid[0]), 64'd0);
    checkOutput("t2 drain hold", 64'(obs_data[0]), 64'h00000000A5A5A5A5);

    // 3-way instance: a select past the last channel grants nobody.
    drv_data[1][0] = 32'h11;
    drv_data[1][1] = 32'h22;
    drv_data[1][2] = 32'h33;
    applyStimulus(1, 4'b0111, 0, 1'b0, 1'b1);
    tick(1);
    checkOutput("t4 first data", 64'(obs_data[1]), 64'h11);
    drv_sel[1] = 2'd3;
    #1;
    checkOutput("t4 sel3 ready", 64'(obs_ready[1]), 64'd0);
    tick(1);
    checkOutput("t4 sel3 valid", 64'(obs_valid[1]), 64'd0);
    drv_sel[1] = 2'd2;
    tick(1);
    checkOutput("t4 sel2 valid", 64'(obs_valid[1]), 64'd1);
    checkOutput("t4 sel2 data", 64'(obs_data[1]), 64'h33);
    checkOutput("t4 sel2 src", 64'(obs_src[1]), 64'd2);
    drv_valid[1] = '0;

    // Reset while the 4-way instance holds a stalled word.
    drv_data[2][1] = 32'hBEEF;
    applyStimulus(2, 4'b0010, 1, 1'b0, 1'b0);
    tick(2);
    checkOutput("t5 loaded", 64'(obs_data[2]), 64'hBEEF);
    reset = 1'b1;
    drv_oready[2] = 1'b1;
    #1;
    checkOutput("t5 ready in reset", 64'(obs_ready[2]), 64'd0);
    tick(1);
    checkOutput("t5 valid", 64'(obs_valid[2]), 64'd0);
    checkOutput("t5 data", 64'(obs_data[2]), 64'd0);
    checkOutput("t5 src", 64'(obs_src[2]), 64'd0);
    reset = 1'b0;

    // Round-robin over all four channels, then over channels 1 and 3.
    for (int i = 0; i < MAXN; i++) drv_data[2][i] = 32'(16'hC000 + i);
    applyStimulus(2, 4'b1111, 0, 1'b1, 1'b1);
    log_en = 1'b1;
    tick(5);
    drv_valid[2] = 4'b1010;
    tick(4);
    @(negedge clk);
    #1;
    log_en = 1'b0;
    if (RR_BUILD) exp_log = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
    else exp_log = '{0, 0, 0, 0, 0};
    checkOutput("rr log length", 64'(rr_log.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < rr_log.size(); i++)
      checkOutput($sformatf("rr src[%0d]", i), 64'(rr_log[i]), 64'(exp_log[i]));
    drv_valid[2] = '0;
    tick(2);

    // Mixed traffic on every instance.
    for (int k = 0; k < 120; k++) begin
      for (int g = 0; g < NCFG; g++) begin
        applyStimulus(g, 4'($urandom), $urandom_range(0, 3),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < MAXN; i++) drv_data[g][i] = $urandom;
      end
      tick(1);
    end
    for (int g = 0; g < NCFG; g++) applyStimulus(g, '0, 0, 1'b0, 1'b1);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
